// File: rtl/bram_arb_pkg.sv
// Shared defaults and encodings for the dual-port BRAM round-robin arbiter.
package bram_arb_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);
   localparam int NUM_PORTS      = 2;

   // Index of each BRAM port in the per-port arrays
   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   // Round-robin increment with explicit wrap, safe for non power-of-two counts
   function automatic int wrap_inc(input int v, input int n);
      return (v == n - 1) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/bram_synch_dual_port.sv
// True dual-port synchronous RAM, read-first, one registered dout per port.
module bram_synch_dual_port #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b
);

   logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;

   // Read old contents, then apply writes (read-first on both ports)
   always_ff @(posedge clk) begin
      dout_a_q <= mem_q[addr_a];
      dout_b_q <= mem_q[addr_b];
      if (we_a) mem_q[addr_a] <= din_a;
      if (we_b) mem_q[addr_b] <= din_b;
   end

   assign dout_a = dout_a_q;
   assign dout_b = dout_b_q;

endmodule

// File: rtl/rr_pick2.sv
// Combinational two-winner round-robin picker. The first valid requester in
// scan order (ptr, ptr+1, ...) wins A; the next valid one wins B unless it is
// flagged in conflict_i, in which case B idles for this cycle.
module rr_pick2 #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDW-1:0]     ptr_i,
   input  logic [NUM_REQ-1:0] conflict_i,
   output logic [NUM_REQ-1:0] gnt_a_o,
   output logic [NUM_REQ-1:0] gnt_b_o,
   output logic [IDW-1:0]     id_a_o,
   output logic [IDW-1:0]     id_b_o,
   output logic               vld_a_o,
   output logic               vld_b_o
);

   logic b_seen_a;
   logic b_stop;

   function automatic int rot_idx(input int base, input int off);
      int s;
      s = base + off;
      return (s >= NUM_REQ) ? s - NUM_REQ : s;
   endfunction

   // Port A: first valid requester in scan order
   always_comb begin
      gnt_a_o = '0;
      id_a_o  = '0;
      vld_a_o = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!vld_a_o && valid_i[rot_idx(int'(ptr_i), k)]) begin
            vld_a_o = 1'b1;
            gnt_a_o[rot_idx(int'(ptr_i), k)] = 1'b1;
            id_a_o  = IDW'(rot_idx(int'(ptr_i), k));
         end
      end
   end

   // Port B: second valid requester; a conflicting candidate ends the scan.
   // Kept independent of the A outputs so conflict_i (built from id_a_o) forms no loop.
   always_comb begin
      gnt_b_o  = '0;
      id_b_o   = '0;
      vld_b_o  = 1'b0;
      b_seen_a = 1'b0;
      b_stop   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!b_stop && valid_i[rot_idx(int'(ptr_i), k)]) begin
            if (!b_seen_a) begin
               b_seen_a = 1'b1;
            end else begin
               b_stop = 1'b1;
               if (!conflict_i[rot_idx(int'(ptr_i), k)]) begin
                  vld_b_o = 1'b1;
                  gnt_b_o[rot_idx(int'(ptr_i), k)] = 1'b1;
                  id_b_o  = IDW'(rot_idx(int'(ptr_i), k));
               end
            end
         end
      end
   end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Shares one dual-port BRAM among NUM_REQ requesters: up to two round-robin
// winners per cycle (A then B), read data routed back with latency 2.
module bram_rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
   output logic                          we_a,
   output logic                          we_b,
   output logic [ADDR_WIDTH-1:0]         addr_a,
   output logic [ADDR_WIDTH-1:0]         addr_b,
   output logic [DATA_WIDTH-1:0]         din_a,
   output logic [DATA_WIDTH-1:0]         din_b,
   input  logic [DATA_WIDTH-1:0]         dout_a,
   input  logic [DATA_WIDTH-1:0]         dout_b
);

   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] valid_gated;
   logic [NUM_REQ-1:0] conflict;
   logic [NUM_REQ-1:0] gnt_a, gnt_b;
   logic [IDW-1:0]     id_a, id_b;
   logic               vld_a, vld_b;

   logic [NUM_PORTS-1:0]                 p_vld, p_we;
   logic [NUM_PORTS-1:0][IDW-1:0]        p_id;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] p_addr;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] p_din, p_dout;

   logic [NUM_PORTS-1:0]                 s1_vld_q, s1_rd_q;
   logic [NUM_PORTS-1:0][IDW-1:0]        s1_id_q;

   logic [NUM_REQ-1:0]                   rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

   // Nothing is granted while reset is held
   assign valid_gated = rst ? '0 : req_valid;

   // B candidate conflicts with A when addresses match and either side writes
   always_comb begin
      conflict = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         conflict[i] = (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                        req_addr[int'(id_a)*ADDR_WIDTH +: ADDR_WIDTH]) &&
                       (req_we[i] || req_we[id_a]);
      end
   end

   rr_pick2 #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
      .valid_i    (valid_gated),
      .ptr_i      (rr_ptr_q),
      .conflict_i (conflict),
      .gnt_a_o    (gnt_a),
      .gnt_b_o    (gnt_b),
      .id_a_o     (id_a),
      .id_b_o     (id_b),
      .vld_a_o    (vld_a),
      .vld_b_o    (vld_b)
   );

   assign req_ready = gnt_a | gnt_b;
   assign p_vld     = {vld_b, vld_a};
   assign p_id      = {id_b, id_a};
   assign p_dout    = {dout_b, dout_a};

   // Route each winner onto its BRAM port; idle ports drive zeros
   always_comb begin
      p_we   = '0;
      p_addr = '0;
      p_din  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (p_vld[p]) begin
            p_we[p]   = req_we[p_id[p]];
            p_addr[p] = req_addr[int'(p_id[p])*ADDR_WIDTH +: ADDR_WIDTH];
            p_din[p]  = req_wdata[int'(p_id[p])*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign we_a   = p_we[PORT_A];
   assign we_b   = p_we[PORT_B];
   assign addr_a = p_addr[PORT_A];
   assign addr_b = p_addr[PORT_B];
   assign din_a  = p_din[PORT_A];
   assign din_b  = p_din[PORT_B];

   // Pointer moves just past the last winner of the cycle; holds when idle
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (vld_b)      rr_ptr_d = IDW'(wrap_inc(int'(id_b), NUM_REQ));
      else if (vld_a) rr_ptr_d = IDW'(wrap_inc(int'(id_a), NUM_REQ));
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end

   // Per-port tag: remembers which requester owns the dout arriving next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= '0;
         s1_rd_q  <= '0;
         s1_id_q  <= '0;
      end else begin
         s1_vld_q <= p_vld;
         s1_rd_q  <= ~p_we;
         s1_id_q  <= p_id;
      end
   end

   // Steer returning read data to its owner; data holds between responses
   always_comb begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (s1_vld_q[p] && s1_rd_q[p]) begin
            rsp_valid_d[s1_id_q[p]] = 1'b1;
            rsp_data_d[s1_id_q[p]]  = p_dout[p];
         end
      end
   end

   // Response capture registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Randomized + directed bench for bram_rr_arbiter against a queue-based model.
module tb_bram_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata, rsp_data;
   logic            we_a, we_b;
   logic [AW-1:0]   addr_a, addr_b;
   logic [DW-1:0]   din_a, din_b, dout_a, dout_b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bram_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .we_a(we_a), .we_b(we_b), .addr_a(addr_a), .addr_b(addr_b),
      .din_a(din_a), .din_b(din_b), .dout_a(dout_a), .dout_b(dout_b)
   );

   bram_synch_dual_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_mem (
      .clk(clk),
      .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
      .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit                  mon_en = 1'b0;
   int                  mptr = 0;
   logic [DW-1:0]       mmem [0:(1<<AW)-1];
   logic [N-1:0]        st1_v = '0, st2_v = '0, gnt_seen = '0;
   logic [N-1:0][DW-1:0] st1_d = '0, st2_d = '0, hold = '0;
   int                  lst[$];
   int                  ga, gb;
   logic [N-1:0]        exp_rdy;
   logic [AW+DW:0]      exp_pa, exp_pb;

   function automatic logic [AW-1:0] ad(input int j);
      return req_addr[j*AW +: AW];
   endfunction
   function automatic logic [DW-1:0] wd(input int j);
      return req_wdata[j*DW +: DW];
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         // responses due now come from grants two cycles back
         for (int i = 0; i < N; i++) if (st2_v[i]) hold[i] = st2_d[i];
         chk("rsp_valid", 64'(rsp_valid), 64'(st2_v));
         chk("rsp_data", 64'(rsp_data), 64'(hold));

         lst.delete();
         for (int k = 0; k < N; k++) if (req_valid[(mptr + k) % N]) lst.push_back((mptr + k) % N);
         ga = -1; gb = -1;
         if (!rst && lst.size() > 0) ga = lst[0];
         if (ga >= 0 && lst.size() > 1)
            if (!(ad(lst[1]) == ad(ga) && (req_we[lst[1]] || req_we[ga]))) gb = lst[1];

         exp_rdy = '0;
         exp_pa  = '0;
         exp_pb  = '0;
         if (ga >= 0) begin exp_rdy[ga] = 1'b1; exp_pa = {req_we[ga], ad(ga), wd(ga)}; end
         if (gb >= 0) begin exp_rdy[gb] = 1'b1; exp_pb = {req_we[gb], ad(gb), wd(gb)}; end
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("port_a", 64'({we_a, addr_a, din_a}), 64'(exp_pa));
         chk("port_b", 64'({we_b, addr_b, din_b}), 64'(exp_pb));

         if (rst) begin
            mptr = 0; st1_v = '0; st2_v = '0; hold = '0; gnt_seen = '0;
         end else begin
            st2_v = st1_v; st2_d = st1_d; st1_v = '0;
            if (ga >= 0 && !req_we[ga]) begin st1_v[ga] = 1'b1; st1_d[ga] = mmem[ad(ga)]; end
            if (gb >= 0 && !req_we[gb]) begin st1_v[gb] = 1'b1; st1_d[gb] = mmem[ad(gb)]; end
            if (ga >= 0 && req_we[ga]) mmem[ad(ga)] = wd(ga);
            if (gb >= 0 && req_we[gb]) mmem[ad(gb)] = wd(gb);
            if (gb >= 0)      mptr = (gb + 1) % N;
            else if (ga >= 0) mptr = (ga + 1) % N;
            gnt_seen = exp_rdy;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int i, input bit we, input int a, input int d);
      req_valid[i]          = 1'b1;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = AW'(a);
      req_wdata[i*DW +: DW] = DW'(d);
   endtask

   // Hold requests until granted, dropping each as it is accepted
   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clk); #1;
         req_valid = req_valid & ~gnt_seen;
         n++;
      end while (req_valid != '0 && n < 50);
      chk("grant_timeout", 64'(req_valid == '0), 64'(1));
      req_valid = '0;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // reset held with every requester valid
      for (int i = 0; i < N; i++) set_req(i, 1'b1, i, 8'h10 + i);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      wait_idle();

      // populate the small address window used by the reads below
      for (int a = 0; a < 16; a++) begin
         set_req(0, 1'b1, a, a * 7 + 3);
         wait_idle();
      end

      // write then read back through requester 0
      set_req(0, 1'b1, 5, 8'hA5); wait_idle();
      set_req(0, 1'b0, 5, 0);     wait_idle();
      repeat (3) @(posedge clk); #1;
      chk("t2_rdata", 64'(rsp_data[7:0]), 64'(8'hA5));

      // back-to-back reads from all requesters
      for (int i = 0; i < N; i++) set_req(i, 1'b0, $urandom_range(15), 0);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) if (gnt_seen[i]) set_req(i, 1'b0, $urandom_range(15), 0);
      end
      wait_idle();

      // write/read same address: B must idle, read sees the new data
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      set_req(1, 1'b1, 7, 8'h3C);
      set_req(2, 1'b0, 7, 0);
      wait_idle();
      repeat (3) @(posedge clk); #1;
      chk("t4_rdata", 64'(rsp_data[23:16]), 64'(8'h3C));

      // two reads of one address are both granted
      set_req(0, 1'b1, 9, 8'h11); wait_idle();
      set_req(0, 1'b0, 9, 0);
      set_req(3, 1'b0, 9, 0);
      wait_idle();
      repeat (3) @(posedge clk); #1;
      chk("t5_rdata0", 64'(rsp_data[7:0]), 64'(8'h11));
      chk("t5_rdata3", 64'(rsp_data[31:24]), 64'(8'h11));

      // reset right after a read handshake discards it
      set_req(0, 1'b0, 3, 0);
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, i + 4, 0);
      wait_idle();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || gnt_seen[i]) begin
               req_valid[i]          = ($urandom_range(3) != 0);
               req_we[i]             = 1'($urandom_range(1));
               req_addr[i*AW +: AW]  = AW'($urandom_range(15));
               req_wdata[i*DW +: DW] = DW'($urandom);
            end
         end
      end
      wait_idle();
      repeat (4) @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
